// File: rtl/c499_ecc_encoder_if.sv
// rtl/c499_ecc_encoder_if.sv - stream and status bundle for the c499 check-bit encoder
interface c499_ecc_encoder_if #(
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              inj_en;
  logic [5:0]        inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [7:0]        out_check;
  logic [CNT_W-1:0]  word_count;
  logic [7:0]        inj_count;

  // Producer / consumer side driving the encoder
  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_check, word_count, inj_count
  );

  // Encoder side
  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_check, word_count, inj_count
  );
endinterface

// File: rtl/c499_ecc_encoder.sv
// rtl/c499_ecc_encoder.sv - two-stage SEC check-bit encoder with single-bit error injection
module c499_ecc_encoder #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  c499_ecc_encoder_if.slave   io_bus
);
  logic              w_adv1;
  logic              w_adv2;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [3:0]        w_col_lo;
  logic [3:0]        w_col_hi;
  logic [3:0]        w_grp;
  logic [7:0]        w_check;
  logic [31:0]       w_flip_d;
  logic [7:0]        w_flip_c;
  logic              w_inj_hit;

  logic              r_v1;
  logic [31:0]       r_d1;
  logic [3:0]        r_col_lo;
  logic [3:0]        r_col_hi;
  logic [3:0]        r_grp;
  logic              r_inj_en1;
  logic [5:0]        r_inj_pos1;

  logic              r_v2;
  logic [31:0]       r_d2;
  logic [7:0]        r_c2;
  logic              r_inj2;

  logic [CNT_W-1:0]  r_word_count;
  logic [7:0]        r_inj_count;

  assign w_adv2     = !r_v2 | io_bus.out_ready;
  assign w_adv1     = !r_v1 | w_adv2;
  assign w_in_fire  = io_bus.in_valid & w_adv1;
  assign w_out_fire = r_v2 & io_bus.out_ready;

  assign io_bus.in_ready   = w_adv1;
  assign io_bus.out_valid  = r_v2;
  assign io_bus.out_data   = r_d2;
  assign io_bus.out_check  = r_c2;
  assign io_bus.word_count = r_word_count;
  assign io_bus.inj_count  = r_inj_count;

  // Stage-1 partial XORs: bit k of each nibble in the low/high halves, and byte parities
  always_comb begin
    w_col_lo = '0;
    w_col_hi = '0;
    w_grp    = '0;
    for (int k = 0; k < 4; k++) begin
      w_col_lo[k] = io_bus.in_data[k]      ^ io_bus.in_data[k+4]  ^
                    io_bus.in_data[k+8]    ^ io_bus.in_data[k+12];
      w_col_hi[k] = io_bus.in_data[k+16]   ^ io_bus.in_data[k+20] ^
                    io_bus.in_data[k+24]   ^ io_bus.in_data[k+28];
      w_grp[k]    = ^io_bus.in_data[8*k +: 8];
    end
  end

  // Stage-2 check bits from clean data, then the single flip mask for injection
  always_comb begin
    w_check    = '0;
    w_check[0] = r_col_lo[0] ^ r_grp[2];
    w_check[1] = r_col_lo[1] ^ r_grp[3];
    w_check[2] = r_col_lo[2] ^ (^r_d1[19:16]) ^ (^r_d1[27:24]);
    w_check[3] = r_col_lo[3] ^ (^r_d1[23:20]) ^ (^r_d1[31:28]);
    w_check[4] = r_grp[0] ^ r_col_hi[0];
    w_check[5] = r_grp[1] ^ r_col_hi[1];
    w_check[6] = (^r_d1[3:0]) ^ (^r_d1[11:8])  ^ r_col_hi[2];
    w_check[7] = (^r_d1[7:4]) ^ (^r_d1[15:12]) ^ r_col_hi[3];
    w_flip_d   = '0;
    w_flip_c   = '0;
    w_inj_hit  = r_inj_en1 && (r_inj_pos1 < 6'd40);
    if (r_inj_en1) begin
      if (!r_inj_pos1[5]) begin
        w_flip_d[r_inj_pos1[4:0]] = 1'b1;
      end else if (r_inj_pos1[5:3] == 3'b100) begin
        w_flip_c[r_inj_pos1[2:0]] = 1'b1;
      end
    end
  end

  // Stage-1 register: capture the word and its partial XORs when the stage can advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_d1       <= '0;
      r_col_lo   <= '0;
      r_col_hi   <= '0;
      r_grp      <= '0;
      r_inj_en1  <= 1'b0;
      r_inj_pos1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= io_bus.in_valid;
      if (w_in_fire) begin
        r_d1       <= io_bus.in_data;
        r_col_lo   <= w_col_lo;
        r_col_hi   <= w_col_hi;
        r_grp      <= w_grp;
        r_inj_en1  <= io_bus.inj_en;
        r_inj_pos1 <= io_bus.inj_pos;
      end
    end
  end

  // Stage-2 register: codeword with injection applied, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_d2   <= '0;
      r_c2   <= '0;
      r_inj2 <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_d2   <= r_d1 ^ w_flip_d;
        r_c2   <= w_check ^ w_flip_c;
        r_inj2 <= w_inj_hit;
      end
    end
  end

  // Transfer counters: wrapping word count, saturating injected-word count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
      r_inj_count  <= '0;
    end else if (w_out_fire) begin
      r_word_count <= r_word_count + CNT_W'(1);
      if (r_inj2 && (r_inj_count != 8'hFF)) begin
        r_inj_count <= r_inj_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_c499_ecc_encoder.sv
// tb/tb_c499_ecc_encoder.sv - self-checking bench for c499_ecc_encoder
module tb_c499_ecc_encoder;
  localparam int CW = 4;
  localparam logic [31:0] MASK [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  typedef struct {
    logic [31:0] dout;
    logic [7:0]  cout;
    logic [31:0] orig;
    logic        hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   exp_wc = 0;
  int   exp_ic = 0;
  bit   last_acc;
  exp_t sb [$];

  always #5 clk = ~clk;

  c499_ecc_encoder_if #(.CNT_W(CW)) bus ();
  c499_ecc_encoder #(.CNT_W(CW)) u_dut (.clk(clk), .rst(rst), .io_bus(bus));

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) c[k] = ^(d & MASK[k]);
    return c;
  endfunction

  function automatic logic [31:0] ref_correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [7:0]  sig;
    logic [31:0] r;
    r   = d;
    syn = c ^ ref_check(d);
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 8; k++) sig[k] = MASK[k][i];
      if (syn == sig) r[i] = ~r[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic model_push();
    exp_t e;
    int   p;
    p      = int'(bus.inj_pos);
    e.orig = bus.in_data;
    e.dout = bus.in_data;
    e.cout = ref_check(bus.in_data);
    e.hit  = 1'b0;
    if (bus.inj_en && p < 40) begin
      e.hit = 1'b1;
      if (p < 32) e.dout[p] = ~e.dout[p];
      else        e.cout[p-32] = ~e.cout[p-32];
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("word_count", 64'(bus.word_count), 64'(exp_wc % (1 << CW)));
    chk("inj_count", 64'(bus.inj_count), 64'(exp_ic));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow: got output %0h want none", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.dout));
        chk("out_check", 64'(bus.out_check), 64'(e.cout));
        chk("corrected", 64'(ref_correct(bus.out_data, bus.out_check)), 64'(e.orig));
        exp_wc++;
        if (e.hit && exp_ic < 255) exp_ic++;
      end
    end
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    exp_wc = 0;
    exp_ic = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_one(input logic [31:0] d, input logic en, input logic [5:0] pos);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.inj_en    = en;
    bus.inj_pos   = pos;
    step();
    chk("send_acc", 64'(last_acc), 64'(1));
    chk("s1_not_out", 64'(bus.out_valid), 64'(0));
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'b0;
    step();
    chk("latency", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic run_random(input int n, input bit inj);
    int sent = 0;
    int cyc  = 0;
    bus.in_valid = 1'b0;
    while ((sent < n || sb.size() > 0) && cyc < n * 4) begin
      if (!bus.in_valid && sent < n && $urandom_range(0, 4) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        bus.inj_en   = inj;
        bus.inj_pos  = inj ? 6'($urandom_range(0, 39)) : 6'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      cyc++;
    end
    chk("random_sent", 64'(sent), 64'(n));
    chk("random_drained", 64'(sb.size()), 64'(0));
  endtask

  logic [31:0] kv_d [4] = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
  logic [7:0]  kv_c [4] = '{8'h00, 8'h51, 8'h8A, 8'h00};
  logic [31:0] d_a;
  logic [31:0] d_b;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.inj_en = 1'b0;
    bus.inj_pos = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_check", 64'(bus.out_check), 64'(0));
    chk("rst_word_count", 64'(bus.word_count), 64'(0));
    chk("rst_inj_count", 64'(bus.inj_count), 64'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 4; i++) begin
      send_one(kv_d[i], 1'b0, 6'd0);
      chk("kv_check", 64'(bus.out_check), 64'(kv_c[i]));
      chk("kv_data", 64'(bus.out_data), 64'(kv_d[i]));
      step();
    end

    send_one(32'h0, 1'b1, 6'd5);
    chk("inj5_data", 64'(bus.out_data), 64'h20);
    chk("inj5_check", 64'(bus.out_check), 64'h00);
    step();
    send_one(32'h0, 1'b1, 6'd33);
    chk("inj33_data", 64'(bus.out_data), 64'h0);
    chk("inj33_check", 64'(bus.out_check), 64'h02);
    step();
    send_one(32'h0, 1'b1, 6'd45);
    chk("inj45_data", 64'(bus.out_data), 64'h0);
    chk("inj45_check", 64'(bus.out_check), 64'h00);
    step();
    chk("inj45_count", 64'(bus.inj_count), 64'd2);
    chk("after_inj_wc", 64'(bus.word_count), 64'd7);

    d_a = $urandom;
    d_b = $urandom;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d_a;
    step();
    chk("bp_acc_a", 64'(last_acc), 64'(1));
    bus.in_data = d_b;
    step();
    chk("bp_acc_b", 64'(last_acc), 64'(1));
    bus.in_data = $urandom;
    chk("bp_full_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    chk("bp_no_acc_c", 64'(last_acc), 64'(0));
    step();
    chk("bp_hold_data", 64'(bus.out_data), 64'(d_a));
    chk("bp_hold_check", 64'(bus.out_check), 64'(ref_check(d_a)));
    chk("bp_still_full", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    step();
    chk("bp_acc_c", 64'(last_acc), 64'(1));
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("bp_word_count", 64'(bus.word_count), 64'd10);

    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = $urandom;
    step();
    bus.in_data = $urandom;
    step();
    bus.in_valid = 1'b0;
    chk("mid_full_valid", 64'(bus.out_valid), 64'(1));
    chk("mid_full_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_data", 64'(bus.out_data), 64'(0));
    chk("mid_rst_check", 64'(bus.out_check), 64'(0));
    chk("mid_rst_wc", 64'(bus.word_count), 64'(0));
    chk("mid_rst_ic", 64'(bus.inj_count), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    sb.delete();
    exp_wc = 0;
    exp_ic = 0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_no_xfer", 64'(bus.word_count), 64'(0));
    rst = 1'b0;
    send_one(32'h00000001, 1'b0, 6'd0);
    chk("post_rst_check", 64'(bus.out_check), 64'h51);
    step();
    chk("post_rst_wc", 64'(bus.word_count), 64'd1);

    do_reset();
    bus.out_ready = 1'b1;
    bus.inj_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      step();
      chk("tput_acc", 64'(last_acc), 64'(1));
      if (i >= 1) chk("tput_out_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("tput_wrap_wc", 64'(bus.word_count), 64'd1);

    run_random(10000, 1'b0);
    run_random(10000, 1'b1);
    chk("inj_saturated", 64'(bus.inj_count), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c499_ecc_encoder.md
# c499_ecc_encoder

Pipelined single-error-correcting (SEC) check-bit generator for 32-bit data words. It produces the 8 check bits that the c499 corrector consumes, so that c499 with its enable input N137=1 sees an all-zero syndrome and passes data through unchanged. The block sits on the write side of the datapath, between the data producer and the c499 corrector. It is valid/ready streamed and includes a single-bit error-injection port so benches can exercise the corrector.

## Interface
Parameters:
- CNT_W, default 16: width of the transfer counter.

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  encoder accepts the input word this cycle.
- in_data  in  32  data bits D0..D31; D[i] maps to corrector input N(1+4i).
- inj_en  in  1  inject a single-bit error into this word; sampled with in_data.
- inj_pos  in  6  bit to flip. 0..31 flips D[pos]; 32..39 flips C[pos-32]; 40..63 flips nothing.
- out_valid  out  1  codeword present.
- out_ready  in  1  downstream accepts the codeword.
- out_data  out  32  data bits, with any injected flip applied.
- out_check  out  8  check bits C0..C7; C[k] maps to N(129+k).
- word_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.
- inj_count  out  8  number of output words that carried an injected flip; saturates at 255.

## Operation
Check equations (^ = XOR):
- C0 = D0^D4^D8^D12^D16^D17^D18^D19^D20^D21^D22^D23
- C1 = D1^D5^D9^D13^D24^D25^D26^D27^D28^D29^D30^D31
- C2 = D2^D6^D10^D14^D16^D17^D18^D19^D24^D25^D26^D27
- C3 = D3^D7^D11^D15^D20^D21^D22^D23^D28^D29^D30^D31
- C4 = D0^D1^D2^D3^D4^D5^D6^D7^D16^D20^D24^D28
- C5 = D8^D9^D10^D11^D12^D13^D14^D15^D17^D21^D25^D29
- C6 = D0^D1^D2^D3^D8^D9^D10^D11^D18^D22^D26^D30
- C7 = D4^D5^D6^D7^D12^D13^D14^D15^D19^D23^D27^D31
- Check bits are always computed from the un-flipped data. Injection is applied afterwards, so exactly one codeword bit differs from a clean encode.

Pipeline, two stages:
- S1 registers: in_data, the eight 4-bit column XORs, the four 8-bit row-group XORs (D0-7, D8-15, D16-23, D24-31), inj_en, inj_pos, and valid v1.
- S2 registers: out_data and out_check with injection applied, an injected flag, and valid v2.
- adv2 = !v2 | out_ready. adv1 = !v1 | adv2. in_ready = adv1. All of these are combinational.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- No bubbles: with out_ready held high, one word per cycle.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- word_count increments on every output transfer and wraps to 0.
- inj_count increments on an output transfer whose word carried a flip (inj_en=1 and inj_pos<40), saturating at 255.

## Timing
- Reset state (asynchronous): v1=v2=0, out_valid=0, out_data=0, out_check=0, word_count=0, inj_count=0. in_ready is 1 while reset is deasserted and the pipeline is empty.
- Reset asserted mid-stream discards all in-flight words. No output transfer occurs in the reset cycle.
- Latency: a word accepted on edge t appears with out_valid=1 after edge t+1, so it is visible in the cycle after its S1 cycle.
- out_data and out_check are held stable while out_valid=1 and out_ready=0 (AXI-style hold).
- Simultaneous accept and transfer in the same cycle with both stages full: S2 is loaded from S1, and S1 is loaded from the input.
- Full stall: after two accepts with out_ready=0, in_ready=0 until the next output transfer.

## Test plan
- Known vectors, inj_en=0 -> check bits:
  - 0x00000000 -> out_check 0x00.
  - 0x00000001 -> 0x51.
  - 0x80000000 -> 0x8A.
  - 0xFFFFFFFF -> 0x00.
- Random stream of 10k words through a reference c499 with N137=1 -> corrector outputs equal in_data for every word. Repeat with inj_pos random in 0..39 -> corrector still returns the original data.
- Injection: data 0, inj_pos=5 -> out_data 0x00000020, out_check 0x00. inj_pos=33 -> out_data 0, out_check 0x02. inj_pos=45 -> clean word, inj_count unchanged.
- Backpressure: out_ready=0, three words offered -> two accepted, in_ready=0 on the third. After out_ready=1, the words emerge in order with stable data during the stall; word_count=3.
- Throughput and wrap: CNT_W=4, out_ready=1, 17 consecutive words -> one output per cycle after 2-cycle fill; word_count=1 at the end.
- Reset mid-stream: assert rst with both stages valid -> out_valid=0 immediately, counters 0. After release, the first new word emits with correct check bits.
